// File: rtl/seq_patdet.sv
// Serial bit-pattern detector: runtime-loadable pattern up to PAT_W bits, with
// overlapping or non-overlapping detection and a saturating match counter.
module seq_patdet #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 16,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             data_in,
   input  logic             data_vld,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] pat,
   input  logic [LEN_W-1:0] pat_len,
   input  logic             overlap_en,
   input  logic             cnt_clr,
   output logic             flag_det,
   output logic             cfg_err,
   output logic             armed,
   output logic [CNT_W-1:0] match_cnt
);

   typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

   localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

   state_t           state, state_nx;
   logic [PAT_W-1:0] hist, hist_nx, cfg_pat, mask;
   logic [LEN_W-1:0] cfg_len, fcnt, fcnt_inc, fcnt_nx;
   logic             cfg_ovl, cfg_ok, step, match;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Only the low cfg_len bits of the history take part in the compare
   always_comb begin
      mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (i < 32'(cfg_len));
      end
   end

   always_comb begin
      cfg_ok   = cfg_load && (pat_len != '0) && (pat_len <= PAT_W_L);
      step     = data_vld && !cfg_ok && (state != IDLE);
      hist_nx  = {hist[PAT_W-2:0], data_in};
      fcnt_inc = (fcnt == PAT_W_L) ? fcnt : fcnt + LEN_W'(1);
      match    = step && (((hist_nx ^ cfg_pat) & mask) == '0) && (fcnt_inc >= cfg_len);
   end

   always_comb begin
      state_nx = state;
      fcnt_nx  = fcnt;
      if (cfg_ok) begin
         state_nx = FILL;
         fcnt_nx  = '0;
      end else if (step) begin
         // Non-overlapping mode restarts the fill so the next match needs fresh bits
         if (match && !cfg_ovl) begin
            state_nx = FILL;
            fcnt_nx  = '0;
         end else begin
            fcnt_nx  = fcnt_inc;
            state_nx = (fcnt_inc >= cfg_len) ? ARMED : FILL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist      <= '0;
         fcnt      <= '0;
         cfg_pat   <= '0;
         cfg_len   <= '0;
         cfg_ovl   <= 1'b0;
         flag_det  <= 1'b0;
         cfg_err   <= 1'b0;
         match_cnt <= '0;
      end else begin
         fcnt     <= fcnt_nx;
         flag_det <= match;
         cfg_err  <= cfg_load && !cfg_ok;
         if (cfg_ok) begin
            cfg_pat <= pat;
            cfg_len <= pat_len;
            cfg_ovl <= overlap_en;
            hist    <= '0;
         end else if (step) begin
            hist <= hist_nx;
         end
         if (cnt_clr) begin
            match_cnt <= match ? CNT_W'(1) : '0;
         end else if (match) begin
            match_cnt <= sat_inc(match_cnt);
         end
      end
   end

   assign armed = (state == ARMED);

endmodule

// File: tb/tb_seq_patdet.sv
// Directed bench for seq_patdet (PAT_W=8, CNT_W=2): vector table plus
// hand-written gap, saturation and mid-pattern reset sequences.
module tb_seq_patdet;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       data_in, data_vld, cfg_load, overlap_en, cnt_clr;
   logic [7:0] pat;
   logic [3:0] pat_len;
   logic       flag_det, cfg_err, armed;
   logic [1:0] match_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   seq_patdet #(.PAT_W(8), .CNT_W(2), .LEN_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_vld(data_vld),
      .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len), .overlap_en(overlap_en),
      .cnt_clr(cnt_clr), .flag_det(flag_det), .cfg_err(cfg_err), .armed(armed),
      .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ld;
      logic [7:0] pat;
      logic [3:0] len;
      logic       ovl;
      logic       vld;
      logic       din;
      logic       clr;
      logic       flag;
      logic       err;
      logic       arm;
      logic [1:0] cnt;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic [7:0] p, input logic [3:0] l,
                        input logic ov, input logic vl, input logic di, input logic cl);
      cfg_load   = ld;
      pat        = p;
      pat_len    = l;
      overlap_en = ov;
      data_vld   = vl;
      data_in    = di;
      cnt_clr    = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] a5;
      int         c;
      logic [1:0] exp_cnt [7];
      logic [2:0] bits101;

      rst_n = 1'b0;
      cfg_load = 0; pat = 0; pat_len = 0; overlap_en = 0; data_vld = 0; data_in = 0; cnt_clr = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_flag", flag_det, 0);
      chk("reset_err", cfg_err, 0);
      chk("reset_armed", armed, 0);
      chk("reset_cnt", match_cnt, 0);
      rst_n = 1'b1;

      //              ld  pat    len  ovl vld din clr  flag err arm cnt
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}); // IDLE ignores data
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
      vq.push_back('{1'b1, 8'h05, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}); // 101 overlap
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2}); // gap freezes
      vq.push_back('{1'b1, 8'hFF, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2}); // len 0 rejected
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2});
      vq.push_back('{1'b1, 8'hFF, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2}); // len 9 rejected
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3}); // old config still detects
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0});
      vq.push_back('{1'b1, 8'h05, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}); // 101 non-overlap
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2});
      vq.push_back('{1'b1, 8'h05, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}); // load beats data
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1});
      vq.push_back('{1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}); // len 1
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3}); // saturates
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1}); // clr + match
      vq.push_back('{1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1}); // len 1 non-overlap
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2});
      vq.push_back('{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2});

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].ld, vq[i].pat, vq[i].len, vq[i].ovl, vq[i].vld, vq[i].din, vq[i].clr);
         chk($sformatf("vec%0d_flag", i), flag_det, vq[i].flag);
         chk($sformatf("vec%0d_err", i), cfg_err, vq[i].err);
         chk($sformatf("vec%0d_armed", i), armed, vq[i].arm);
         chk($sformatf("vec%0d_cnt", i), match_cnt, vq[i].cnt);
      end

      // 8-bit A5 with 0..3 idle cycles between bits
      a5 = 8'hA5;
      drive(1'b1, 8'hA5, 4'd8, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int b = 7; b >= 0; b--) begin
         for (int g = 0; g < ((7 - b) % 4); g++) begin
            idle_cycle();
            chk($sformatf("a5_gap%0d_%0d_flag", b, g), flag_det, 0);
         end
         drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, a5[b], 1'b0);
         chk($sformatf("a5_bit%0d_flag", b), flag_det, (b == 0));
         chk($sformatf("a5_bit%0d_armed", b), armed, (b == 0));
      end
      idle_cycle();
      chk("a5_after_flag", flag_det, 0);
      chk("a5_cnt", match_cnt, 1);

      // Counter sequence with clear on the 4th match, then saturation
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd3};
      drive(1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 7; k++) begin
         c = k;
         drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, (c == 3));
         chk($sformatf("cnt_seq%0d_flag", k), flag_det, 1);
         chk($sformatf("cnt_seq%0d_cnt", k), match_cnt, exp_cnt[k]);
      end

      // Reset in the middle of a 101 pattern
      drive(1'b1, 8'h05, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("reload_keeps_cnt", match_cnt, 3);
      drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      drive(1'b1, 8'h05, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("midrst_flag", flag_det, 0);
      chk("midrst_err", cfg_err, 0);
      chk("midrst_armed", armed, 0);
      chk("midrst_cnt", match_cnt, 0);
      rst_n = 1'b1;
      bits101 = 3'b101;
      for (int b = 2; b >= 0; b--) begin
         drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, bits101[b], 1'b0);
         chk($sformatf("postrst_bit%0d_flag", b), flag_det, 0);
         chk($sformatf("postrst_bit%0d_armed", b), armed, 0);
      end
      drive(1'b1, 8'h05, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int b = 2; b >= 0; b--) begin
         drive(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, bits101[b], 1'b0);
         chk($sformatf("reload_bit%0d_flag", b), flag_det, (b == 0));
      end
      chk("reload_cnt", match_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
